// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-only data memory: extracts and extends loads and
// performs SB/SH as a read-modify-write. Optional feature macro: LSU_MISALIGN_TRAP_EN.
module lsu_subword #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [2:0]               funct3_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic                     ready_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [DATA_WIDTH-1:0]    rdata_o,
    output logic [ADDRESS_WIDTH-1:0] mem_a_o,
    output logic [DATA_WIDTH-1:0]    mem_wd_o,
    output logic                     mem_wen_o,
    input  logic [DATA_WIDTH-1:0]    mem_rd_i
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                   state_q, state_d;
    logic                     we_q, we_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [1:0]               lane_q, lane_d;
    logic [15:0]              wdata_lo_q, wdata_lo_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [ADDRESS_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [DATA_WIDTH-1:0]    mem_wd_q, mem_wd_d;

    logic                     funct3_ok, misaligned, req_err;
    logic [1:0]               lane_eff;
    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [DATA_WIDTH-1:0]    load_val, merged;

    always_comb begin
        if (we_i) begin
            funct3_ok = (funct3_i[2:1] == 2'b00) || (funct3_i == 3'b010);
        end else begin
            funct3_ok = (funct3_i[1:0] != 2'b11) && (funct3_i != 3'b110);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = !funct3_ok || misaligned;

    // Untrapped misalignment drops the offending low bits; the word index is unaffected.
    always_comb begin
        lane_eff = addr_i[1:0];
        case (funct3_i[1:0])
            2'b01:   lane_eff[0] = 1'b0;
            2'b10:   lane_eff    = 2'b00;
            default: ;
        endcase
    end

    assign byte_sel = mem_rd_i[{lane_q, 3'b000} +: 8];
    assign half_sel = mem_rd_i[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_val = funct3_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = funct3_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_rd_i;
        endcase
    end

    always_comb begin
        merged = mem_rd_i;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_lo_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_lo_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        lane_d     = lane_q;
        wdata_lo_d = wdata_lo_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_a_d    = mem_a_q;
        mem_wd_d   = mem_wd_q;
        case (state_q)
            StIdle: begin
                if (req_i) begin
                    we_d       = we_i;
                    funct3_d   = funct3_i;
                    lane_d     = lane_eff;
                    wdata_lo_d = wdata_i[15:0];
                    err_d      = req_err;
                    if (req_err) begin
                        state_d = StDone;
                    end else begin
                        // Memory address only moves for transactions that will use it.
                        mem_a_d = {2'b00, addr_i[ADDRESS_WIDTH-1:2]};
                        if (we_i && (funct3_i == 3'b010)) begin
                            mem_wd_d = wdata_i;
                            state_d  = StWrite;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: begin
                if (we_q) begin
                    mem_wd_d = merged;
                    state_d  = StWrite;
                end else begin
                    rdata_d = load_val;
                    state_d = StDone;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            wdata_lo_q <= 16'h0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            lane_q     <= lane_d;
            wdata_lo_q <= wdata_lo_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign ready_o   = (state_q == StIdle) && !rst_i;
    assign done_o    = (state_q == StDone);
    assign err_o     = (state_q == StDone) && err_q;
    assign mem_wen_o = (state_q == StWrite);
    assign rdata_o   = rdata_q;
    assign mem_a_o   = mem_a_q;
    assign mem_wd_o  = mem_wd_q;

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: directed vector table, reset-abort sequence and random transactions
// checked against a byte-arithmetic reference model of memory and load results.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, err, mem_wen;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] ref_rdata;

    int total = 0;
    int bad = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    lsu_subword #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(funct3), .addr_i(addr),
        .wdata_i(wdata), .ready_o(ready), .done_o(done), .err_o(err), .rdata_o(rdata),
        .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_wen_o(mem_wen), .mem_rd_i(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[5:0]];
    always @(posedge clk) if (mem_wen) mem[mem_a[5:0]] <= mem_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-granular arithmetic over the word array.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output int lat, output bit e,
                                  output int widx, output logic [31:0] nword);
        int size, off, ae;
        logic [31:0] mask, word, val;
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e = 1'b0; lat = 1; widx = 0; nword = 32'h0;
        if (!legal) begin e = 1'b1; return; end
        size = 1 << f3[1:0];
        ae = int'(a[5:0]);
        if (Trap && (ae % size != 0)) begin e = 1'b1; return; end
        ae = ae - ae % size;
        widx = ae / 4;
        off = ae % 4;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        word = ref_mem[widx];
        if (!st) begin
            val = (word >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
            ref_rdata = val;
            lat = 2;
        end else begin
            nword = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            ref_mem[widx] = nword;
            lat = (size == 4) ? 2 : 3;
        end
    endfunction

    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input string tag,
                           output int lat, output bit got_err);
        int exp_lat, widx, wen_cnt;
        bit exp_err;
        logic [31:0] exp_word, wr_a, wr_d;
        model(st, f3, a, wd, exp_lat, exp_err, widx, exp_word);
        @(negedge clk);
        check({tag, " ready"}, {31'h0, ready}, 32'd1);
        req = 1'b1; we = st; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; got_err = 1'b0; wen_cnt = 0; wr_a = 32'h0; wr_d = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_wen) begin wen_cnt++; wr_a = mem_a; wr_d = mem_wd; end
            if (done) begin lat = c; got_err = err; break; end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " err"}, {31'h0, got_err}, {31'h0, exp_err});
        check({tag, " rdata"}, rdata, ref_rdata);
        check({tag, " wen cycles"}, wen_cnt, (st && !exp_err) ? 1 : 0);
        if (st && !exp_err) begin
            check({tag, " wr addr"}, wr_a, widx);
            check({tag, " wr data"}, wr_d, exp_word);
            check({tag, " mem word"}, mem[widx], ref_mem[widx]);
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        bit          e;
        logic [31:0] rd;
        logic [31:0] m4;
    } vec_t;

    localparam int NVec = 13;
    vec_t vecs [NVec];

    initial begin
        int lat;
        bit e;
        vecs[0]  = '{1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFF88, 32'h8899AABB};
        vecs[1]  = '{1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0, 32'h00008899, 32'h8899AABB};
        vecs[2]  = '{1'b0, 3'b001, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFAABB, 32'h8899AABB};
        vecs[3]  = '{1'b1, 3'b000, 32'h11, 32'h123456CC, 3, 1'b0, 32'hFFFFAABB, 32'h8899CCBB};
        vecs[4]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'hFFFFAABB, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 3'b100, 32'h11, 32'h0, 2, 1'b0, 32'h000000BE, 32'hDEADBEEF};
        vecs[7]  = Trap ? '{1'b0, 3'b010, 32'h12, 32'h0, 1, 1'b1, 32'h000000BE, 32'hDEADBEEF}
                        : '{1'b0, 3'b010, 32'h12, 32'h0, 2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, vecs[7].rd, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 3'b100, 32'h10, 32'h55555555, 1, 1'b1, vecs[7].rd, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 3'b001, 32'h12, 32'hFFFF9234, 3, 1'b0, vecs[7].rd, 32'h9234BEEF};
        vecs[11] = Trap ? '{1'b0, 3'b001, 32'h13, 32'h0, 1, 1'b1, 32'h000000BE, 32'h9234BEEF}
                        : '{1'b0, 3'b001, 32'h13, 32'h0, 2, 1'b0, 32'hFFFF9234, 32'h9234BEEF};
        vecs[12] = '{1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0, 32'h00009234, 32'h9234BEEF};

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;
        ref_rdata = 32'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", {31'h0, ready}, 32'd0);
        check("rst done", {31'h0, done}, 32'd0);
        check("rst err", {31'h0, err}, 32'd0);
        check("rst wen", {31'h0, mem_wen}, 32'd0);
        check("rst rdata", rdata, 32'h0);
        check("rst mem_a", mem_a, 32'h0);
        check("rst mem_wd", mem_wd, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready after rst", {31'h0, ready}, 32'd1);

        for (int i = 0; i < NVec; i++) begin
            run_txn(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, $sformatf("vec%0d", i), lat, e);
            check($sformatf("vec%0d tbl latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d tbl err", i), {31'h0, e}, {31'h0, vecs[i].e});
            check($sformatf("vec%0d tbl rdata", i), rdata, vecs[i].rd);
            check($sformatf("vec%0d tbl mem4", i), mem[4], vecs[i].m4);
        end

        // SH aborted by reset while in READ: no write, no done, state cleared.
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h10; wdata = 32'h0000AAAA;
        @(posedge clk);
        #1 begin req = 1'b0; rst = 1'b1; end
        @(negedge clk);
        check("abort ready in rst", {31'h0, ready}, 32'd0);
        check("abort wen in rst", {31'h0, mem_wen}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ref_rdata = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) check("abort ready after rst", {31'h0, ready}, 32'd1);
            check("abort done", {31'h0, done}, 32'd0);
            check("abort wen", {31'h0, mem_wen}, 32'd0);
        end
        check("abort mem4", mem[4], 32'h9234BEEF);
        check("abort rdata", rdata, 32'h0);

        for (int i = 0; i < 200; i++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'($urandom_range(0, 63)), $urandom, $sformatf("rnd%0d", i), lat, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit between the execute stage and `data_mem`, which only reads and writes whole 32-bit words. The unit converts byte/halfword/word requests into word-indexed memory accesses. Loads are extracted and extended. Sub-word stores are done as a multi-cycle read-modify-write. All memory control comes from a registered FSM, so `data_mem`'s level-sensitive write enable is never glitched.

## Interface
- `ADDRESS_WIDTH`, 32, byte-address width of request and memory address.
- `DATA_WIDTH`, 32, data width; fixed at 32 (four byte lanes).
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_i` input 1: request valid; accepted only when `ready_o`=1.
- `we_i` input 1: 1=store, 0=load.
- `funct3_i` input 3: RV32I width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `addr_i` input ADDRESS_WIDTH: byte address.
- `wdata_i` input DATA_WIDTH: store data; low byte/halfword used for SB/SH.
- `ready_o` output 1: idle, can accept a request.
- `done_o` output 1: one-cycle completion pulse.
- `err_o` output 1: valid with `done_o`; illegal funct3 or trapped misalignment.
- `rdata_o` output DATA_WIDTH: load result; held until the next load completes.
- `mem_a_o` output ADDRESS_WIDTH: word index, `addr >> 2`; drives `data_mem` `a_i`.
- `mem_wd_o` output DATA_WIDTH: word to write.
- `mem_wen_o` output 1: write enable to `data_mem`.
- `mem_rd_i` input DATA_WIDTH: combinational read data from `data_mem`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `ready_o`=1.
  - On `req_i`, latch `we_i`, `funct3_i`, `addr_i` and `wdata_i` into internal registers.
  - Illegal funct3 (load 011/110/111; store 1xx/011) goes to DONE with err=1.
  - Trapped misalignment goes to DONE with err=1.
  - SW goes to WRITE.
  - All other accepted requests go to READ.
- **READ** (one cycle)
  - `mem_a_o` = latched word index.
  - Load: extract the lane and register it in `rdata_o`, then go to DONE.
  - Sub-word store: capture `mem_rd_i`, merge the new lane(s) into it, then go to WRITE.
- **WRITE** (one cycle)
  - `mem_wen_o`=1, decoded from the state register only.
  - `mem_a_o` and `mem_wd_o` come from registers and are stable for the whole cycle.
  - Go to DONE.
- **DONE**
  - `done_o`=1 and `err_o` valid; go to IDLE.
- Lane selection is little-endian.
  - Byte lane = addr[1:0].
  - Halfword lane = addr[1].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- `mem_wen_o` is 0 in every state except WRITE.
- Errored transactions never assert `mem_wen_o` and leave `rdata_o` unchanged.
- `req_i` is ignored while not in IDLE; there is no queueing.
- `mem_a_o` and `mem_wd_o` hold their last value outside READ/WRITE.

## Timing
- Request accepted at edge 0 (IDLE, `req_i`=1). `done_o` is high in cycle:
  - 2 for loads (READ, DONE);
  - 3 for SB/SH (READ, WRITE, DONE);
  - 2 for SW (WRITE, DONE);
  - 1 for errors.
- `ready_o` returns in the cycle after `done_o`, so back-to-back issue is possible every latency+1 cycles.
- Reset values: state IDLE; `done_o`, `err_o`, `mem_wen_o`=0; `rdata_o`, `mem_a_o`, `mem_wd_o`=0.
- `ready_o`=0 while `rst_i`=1, and 1 in the first cycle after reset deasserts.
- Reset mid-operation (any state) aborts the transaction:
  - no `done_o`;
  - any pending write is dropped, with `mem_wen_o` low from the cycle after the reset edge;
  - a transaction aborted during WRITE may already have written that cycle.

## Configuration
- Feature macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0, complete in 1 cycle with `err_o`=1;
  - no memory access occurs.
- **Undefined:** offending low address bits are forced to zero (halfword: addr[0]; word: addr[1:0]) and the access proceeds normally; `err_o` is only raised for illegal funct3.

## Test plan
1. Preload word index 4 = 0x8899AABB; LB, addr 0x13 → `rdata_o`=0xFFFFFF88, `done_o` in cycle 2, `err_o`=0, `mem_wen_o` never high.
2. Same memory; LHU, addr 0x12 → `rdata_o`=0x00008899; LH, addr 0x10 → `rdata_o`=0xFFFFAABB.
3. SB, addr 0x11, `wdata_i`=0x123456CC → word 4 becomes 0x8899CCBB; `mem_wen_o` high exactly one cycle with `mem_a_o`=4; `done_o` in cycle 3.
4. SW, addr 0x10, 0xDEADBEEF → no READ cycle, `done_o` in cycle 2; a following LW returns 0xDEADBEEF.
5. LW, addr 0x12:
   - macro defined → `done_o` and `err_o` in cycle 1, `rdata_o` unchanged;
   - undefined → returns the word at 0x10.
6. SH, addr 0x10; assert `rst_i` during READ → no write, no `done_o`, `ready_o`=1 one cycle after reset deasserts. Separately: load funct3 011 → `err_o`=1.
